fb_scanout: RTL



---
 rtl/fb_scanout_pkg.sv | 25 ++
 rtl/scanout_skid.sv | 51 +++++
 rtl/fb_scanout.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_pkg.sv
// Shared types and elaboration-time helpers for the frame-buffer scanout engine.
// Holds the FSM state encoding, a ceil-log2 for sizing counters, and the
// output-pixels-per-frame helper used to size the push counter.
package fb_scanout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  // Ceil(log2(n)); returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Output pixels per frame after replication in both axes.
  function automatic int px_per_frame(input int h_res, input int v_res, input int scale);
    return h_res * scale * v_res * scale;
  endfunction

endpackage

// File: rtl/scanout_skid.sv
// Small synchronous FIFO that absorbs BRAM read data while the pixel FIFO is full.
// Zero-latency head: the oldest entry is visible on head whenever count != 0.
// No internal overflow protection; the reader only issues when space is reserved.
module scanout_skid
  import fb_scanout_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 24,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Data storage; stale contents are never visible because count gates use.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer wrap and occupancy tracking; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: walks the source frame with pixel/line replication and
// streams BRAM read data into the pixel FIFO, one pixel per clock when not full.
// Reads are only issued when skid space is reserved, so any fifo_full pattern is lossless.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int SCALE  = 2,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 24,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              page_sel,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [DATA_W-1:0] fb_rd_data,
  output logic              busy,
  output logic              frame_done
);

  // Skid depth covers every read in the BRAM pipe plus two buffered entries.
  localparam int D     = RD_LAT + 2;
  localparam int CNT_W = clog2(D + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int SXW   = clog2(H_RES + 1);
  localparam int SYW   = clog2(V_RES + 1);
  localparam int RW    = clog2(SCALE + 1);
  localparam int NPIX  = px_per_frame(H_RES, V_RES, SCALE);
  localparam int PCW   = clog2(NPIX + 1);

  localparam logic [ADDR_W-1:0] PAGE_SZ = ADDR_W'(H_RES * V_RES);
  localparam logic [ADDR_W-1:0] LINE_SZ = ADDR_W'(H_RES);

  scan_state_t       state;
  logic [SXW-1:0]    sx;
  logic [SYW-1:0]    sy;
  logic [RW-1:0]     rx;
  logic [RW-1:0]     ry;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] page_base;

  logic [RD_LAT-1:0] vpipe;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  skid_count;
  logic [DATA_W-1:0] skid_head;
  logic [PCW-1:0]    push_cnt;

  logic rx_last;
  logic sx_last;
  logic ry_last;
  logic sy_last;
  logic frame_last;
  logic drain_ok;
  logic skid_pop;

  assign rx_last    = (rx == RW'(SCALE - 1));
  assign sx_last    = (sx == SXW'(H_RES - 1));
  assign ry_last    = (ry == RW'(SCALE - 1));
  assign sy_last    = (sy == SYW'(V_RES - 1));
  assign frame_last = rx_last && sx_last && ry_last && sy_last;

  // Count reads still travelling through the BRAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(vpipe[i]);
  end

  assign drain_ok = (skid_count == '0) && (inflight == '0);

  // Issue a read only when its data is guaranteed a skid slot on arrival.
  assign fb_rd_en   = (state == RUN) &&
                      ((SUM_W'(skid_count) + SUM_W'(inflight)) < SUM_W'(D));
  assign fb_rd_addr = page_base + line_base + ADDR_W'(sx);

  // rst gates the push so buffered data is discarded rather than leaked in the reset cycle.
  assign skid_pop   = (skid_count != '0) && !fifo_full && !rst;
  assign fifo_wr_en = skid_pop;
  assign fifo_din   = (skid_count != '0) ? skid_head : '0;
  assign frame_done = skid_pop && (push_cnt == PCW'(NPIX - 1));
  assign busy       = (state != IDLE);

  // FSM plus scan counters; carry order rx -> sx -> ry -> sy, line_base tracks sy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sx        <= '0;
      sy        <= '0;
      rx        <= '0;
      ry        <= '0;
      line_base <= '0;
      page_base <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= RUN;
            page_base <= page_sel ? PAGE_SZ : '0;
            sx        <= '0;
            sy        <= '0;
            rx        <= '0;
            ry        <= '0;
            line_base <= '0;
          end
        end
        RUN: begin
          if (fb_rd_en) begin
            if (rx_last) begin
              rx <= '0;
              if (sx_last) begin
                sx <= '0;
                if (ry_last) begin
                  ry <= '0;
                  if (sy_last) begin
                    sy        <= '0;
                    line_base <= '0;
                  end else begin
                    sy        <= sy + SYW'(1);
                    line_base <= line_base + LINE_SZ;
                  end
                end else begin
                  ry <= ry + RW'(1);
                end
              end else begin
                sx <= sx + SXW'(1);
              end
            end else begin
              rx <= rx + RW'(1);
            end
            if (frame_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            if (enable) begin
              state     <= RUN;
              page_base <= page_sel ? PAGE_SZ : '0;
              sx        <= '0;
              sy        <= '0;
              rx        <= '0;
              ry        <= '0;
              line_base <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid shift register mirroring the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= fb_rd_en;
      for (int i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  // Output pixel index within the frame, used to place the frame_done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_cnt <= '0;
    end else if (skid_pop) begin
      push_cnt <= (push_cnt == PCW'(NPIX - 1)) ? '0 : push_cnt + PCW'(1);
    end
  end

  scanout_skid #(
    .DEPTH (D),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (vpipe[RD_LAT-1]),
    .push_data (fb_rd_data),
    .pop       (skid_pop),
    .head      (skid_head),
    .count     (skid_count)
  );

endmodule
